// File: rtl/pauli_pkg.sv
// Shared definitions for the Pauli frame tracking stages: axis encoding,
// default frame width and the snapshot buffer state type.
package pauli_pkg;

  localparam int DEF_N_QUBITS = 5;

  localparam logic [1:0] AXIS_X = 2'd0;
  localparam logic [1:0] AXIS_Y = 2'd1;
  localparam logic [1:0] AXIS_Z = 2'd2;

  typedef enum logic {
    OB_EMPTY = 1'b0,
    OB_FULL  = 1'b1
  } outbuf_state_t;

  // Axis codes 2 and 3 both mean Z, so the top bit alone identifies Z.
  function automatic logic is_z_axis(input logic [1:0] axis);
    return axis[1];
  endfunction

endpackage

// File: rtl/pauli_frame_outbuf.sv
// Single-entry snapshot register with valid/ready handshake. A snapshot that
// arrives while the entry is occupied and not being drained is dropped and
// recorded in a sticky overflow flag.
module pauli_frame_outbuf
  import pauli_pkg::*;
#(
  parameter int W = 18
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         overflow
);

  outbuf_state_t state, state_next;
  logic          capture;
  logic          drop;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= OB_EMPTY;
    else     state <= state_next;
  end

  // Next state: fill when empty, drain on ready, refill on a same-edge
  // drain+load, otherwise drop the incoming snapshot.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    drop       = 1'b0;
    case (state)
      OB_EMPTY: begin
        if (load) begin
          capture    = 1'b1;
          state_next = OB_FULL;
        end
      end
      OB_FULL: begin
        if (out_ready) begin
          if (load) capture    = 1'b1;
          else      state_next = OB_EMPTY;
        end else if (load) begin
          drop = 1'b1;
        end
      end
    endcase
  end

  // Data holds while the entry waits for the consumer.
  always_ff @(posedge CLK) begin
    if (RST)          out_data <= '0;
    else if (capture) out_data <= load_data;
  end

  // Sticky drop indicator.
  always_ff @(posedge CLK) begin
    if (RST)       overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

  assign out_valid = (state == OB_FULL);

endmodule

// File: rtl/pauli_frame_tracker.sv
// Folds axis-tagged one-hot corrections into a per-qubit Pauli frame and
// emits a frame snapshot every ROUNDS complete X/Y/Z rounds.
module pauli_frame_tracker
  import pauli_pkg::*;
#(
  parameter int N_QUBITS = DEF_N_QUBITS,
  parameter int ROUNDS   = 4,
  parameter int CNT_W    = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  input  logic [N_QUBITS-1:0] correction,
  input  logic [1:0]          axis,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_QUBITS-1:0] frame_x_out,
  output logic [N_QUBITS-1:0] frame_z_out,
  output logic [CNT_W-1:0]    corr_count_out,
  output logic                overflow,
  output logic                fault
);

  localparam int               SNAP_W     = 2 * N_QUBITS + CNT_W;
  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);

  logic [N_QUBITS-1:0] frame_x, frame_z;
  logic [N_QUBITS-1:0] frame_x_next, frame_z_next;
  logic [CNT_W-1:0]    round_cnt, corr_cnt, corr_next;
  logic                x_hit, z_hit;
  logic                round_end, snap_due, multi_hot;
  logic [SNAP_W-1:0]   snap_data, out_data;

  // Frame update, saturating count and window-end detection for this beat.
  always_comb begin
    x_hit        = in_valid && ((axis == AXIS_X) || (axis == AXIS_Y));
    z_hit        = in_valid && (is_z_axis(axis) || (axis == AXIS_Y));
    frame_x_next = frame_x ^ (x_hit ? correction : '0);
    frame_z_next = frame_z ^ (z_hit ? correction : '0);
    corr_next    = corr_cnt;
    if (in_valid && (|correction) && (corr_cnt != '1))
      corr_next = corr_cnt + CNT_W'(1);
    // x & (x-1) is nonzero exactly when more than one bit is set.
    multi_hot = (correction & (correction - N_QUBITS'(1))) != '0;
    round_end = in_valid && is_z_axis(axis);
    snap_due  = round_end && (round_cnt == LAST_ROUND);
  end

  // Accumulators: the window-ending beat's contribution goes into the
  // snapshot, and the working frame restarts empty.
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_x   <= '0;
      frame_z   <= '0;
      corr_cnt  <= '0;
      round_cnt <= '0;
      fault     <= 1'b0;
    end else begin
      if (snap_due) begin
        frame_x   <= '0;
        frame_z   <= '0;
        corr_cnt  <= '0;
        round_cnt <= '0;
      end else begin
        frame_x  <= frame_x_next;
        frame_z  <= frame_z_next;
        corr_cnt <= corr_next;
        if (round_end) round_cnt <= round_cnt + CNT_W'(1);
      end
      if (in_valid && multi_hot) fault <= 1'b1;
    end
  end

  assign snap_data = {frame_x_next, frame_z_next, corr_next};

  pauli_frame_outbuf #(.W(SNAP_W)) u_outbuf (
    .CLK       (CLK),
    .RST       (RST),
    .load      (snap_due),
    .load_data (snap_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .overflow  (overflow)
  );

  assign {frame_x_out, frame_z_out, corr_count_out} = out_data;

endmodule

// File: tb/tb_pauli_frame_tracker.sv
// Bench for pauli_frame_tracker: a ROUNDS=1 instance checked through a
// snapshot scoreboard plus direct checks, and a ROUNDS=2 instance for
// multi-round windows. Both instances share the stimulus.
module tb_pauli_frame_tracker;

  localparam int N  = 5;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [N-1:0]  correction;
  logic [1:0]    axis;
  logic          out_ready;

  logic          ov1, of1, ft1;
  logic [N-1:0]  fx1, fz1;
  logic [CW-1:0] cc1;
  logic          ov2, of2, ft2;
  logic [N-1:0]  fx2, fz2;
  logic [CW-1:0] cc2;

  always #5 clk = ~clk;

  pauli_frame_tracker #(.N_QUBITS(N), .ROUNDS(1), .CNT_W(CW)) u1 (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .correction(correction),
    .axis(axis), .out_valid(ov1), .out_ready(out_ready),
    .frame_x_out(fx1), .frame_z_out(fz1), .corr_count_out(cc1),
    .overflow(of1), .fault(ft1)
  );

  pauli_frame_tracker #(.N_QUBITS(N), .ROUNDS(2), .CNT_W(CW)) u2 (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .correction(correction),
    .axis(axis), .out_valid(ov2), .out_ready(out_ready),
    .frame_x_out(fx2), .frame_z_out(fz2), .corr_count_out(cc2),
    .overflow(of2), .fault(ft2)
  );

  typedef struct packed {
    logic [N-1:0]  fx;
    logic [N-1:0]  fz;
    logic [CW-1:0] cnt;
  } snap_t;

  typedef struct {
    logic [1:0]    a0;
    logic [N-1:0]  c0;
    logic [1:0]    a1;
    logic [N-1:0]  c1;
    logic [1:0]    a2;
    logic [N-1:0]  c2;
    logic [N-1:0]  fx;
    logic [N-1:0]  fz;
    logic [CW-1:0] cnt;
  } vec_t;

  snap_t sbq[$];
  vec_t  vt[5];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [N-1:0] fx, input logic [N-1:0] fz, input logic [CW-1:0] cnt);
    snap_t s;
    s.fx  = fx;
    s.fz  = fz;
    s.cnt = cnt;
    sbq.push_back(s);
  endtask

  // One clock: sample at the falling edge (retiring any u1 handshake against
  // the scoreboard), then return just after the rising edge.
  task automatic tick();
    snap_t e;
    @(negedge clk);
    if (!rst && ov1 && out_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_snapshot: got x=%b z=%b cnt=%0d expected none", fx1, fz1, cc1);
      end else begin
        e = sbq.pop_front();
        chk("snap_x", 32'(fx1), 32'(e.fx));
        chk("snap_z", 32'(fz1), 32'(e.fz));
        chk("snap_cnt", 32'(cc1), 32'(e.cnt));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] a, input logic [N-1:0] c);
    in_valid   = 1'b1;
    axis       = a;
    correction = c;
    tick();
    in_valid   = 1'b0;
    axis       = 2'd0;
    correction = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    correction = '0;
    axis       = 2'd0;
    out_ready  = 1'b0;

    vt[0] = '{2'd0, 5'b10000, 2'd1, 5'b00100, 2'd2, 5'b00001, 5'b10100, 5'b00101, 8'd3};
    vt[1] = '{2'd0, 5'b00001, 2'd1, 5'b00001, 2'd2, 5'b00010, 5'b00000, 5'b00011, 8'd3};
    vt[2] = '{2'd0, 5'b00000, 2'd1, 5'b00000, 2'd2, 5'b00000, 5'b00000, 5'b00000, 8'd0};
    vt[3] = '{2'd1, 5'b01000, 2'd0, 5'b01000, 2'd3, 5'b10000, 5'b00000, 5'b11000, 8'd3};
    vt[4] = '{2'd0, 5'b00100, 2'd0, 5'b00100, 2'd2, 5'b00100, 5'b00000, 5'b00100, 8'd3};

    // Reset and idle.
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    chk("idle_valid", 32'(ov1), 32'd0);
    chk("idle_x", 32'(fx1), 32'd0);
    chk("idle_z", 32'(fz1), 32'd0);
    chk("idle_cnt", 32'(cc1), 32'd0);
    chk("idle_ovf", 32'(of1), 32'd0);
    chk("idle_fault", 32'(ft1), 32'd0);
    chk("idle_valid2", 32'(ov2), 32'd0);

    // Two-round window where the X corrections cancel; axis 3 closes round 2.
    beat(2'd0, 5'b01000);
    beat(2'd1, 5'b00000);
    beat(2'd2, 5'b00000);
    chk("r2_no_snap_after_round1", 32'(ov2), 32'd0);
    beat(2'd0, 5'b01000);
    beat(2'd1, 5'b00000);
    beat(2'd3, 5'b00000);
    chk("r2_snap_valid", 32'(ov2), 32'd1);
    chk("r2_snap_x", 32'(fx2), 32'd0);
    chk("r2_snap_z", 32'(fz2), 32'd0);
    chk("r2_snap_cnt", 32'(cc2), 32'd2);
    do_reset();

    // Table of single-round windows drained immediately.
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      push_exp(vt[v].fx, vt[v].fz, vt[v].cnt);
      beat(vt[v].a0, vt[v].c0);
      beat(vt[v].a1, vt[v].c1);
      chk("no_early_valid", 32'(ov1), 32'd0);
      beat(vt[v].a2, vt[v].c2);
      chk("valid_after_window", 32'(ov1), 32'd1);
      tick();
      chk("valid_pulse_ends", 32'(ov1), 32'd0);
      tick();
    end
    chk("table_no_ovf", 32'(of1), 32'd0);

    // Backpressure: second window is dropped, first is held.
    do_reset();
    out_ready = 1'b0;
    push_exp(5'b00001, 5'b00000, 8'd1);
    beat(2'd0, 5'b00001);
    beat(2'd1, 5'b00000);
    beat(2'd2, 5'b00000);
    chk("bp_valid", 32'(ov1), 32'd1);
    chk("bp_ovf_before", 32'(of1), 32'd0);
    beat(2'd0, 5'b00100);
    beat(2'd2, 5'b00100);
    tick();
    chk("bp_ovf_after", 32'(of1), 32'd1);
    chk("bp_hold_x", 32'(fx1), 32'd1);
    chk("bp_hold_z", 32'(fz1), 32'd0);
    chk("bp_hold_cnt", 32'(cc1), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_valid_drops", 32'(ov1), 32'd0);
    chk("bp_ovf_sticky", 32'(of1), 32'd1);

    // Drain and reload on the same edge: no overflow.
    do_reset();
    out_ready = 1'b0;
    push_exp(5'b10000, 5'b00000, 8'd1);
    beat(2'd0, 5'b10000);
    beat(2'd2, 5'b00000);
    push_exp(5'b01000, 5'b00010, 8'd2);
    beat(2'd0, 5'b01000);
    out_ready = 1'b1;
    beat(2'd2, 5'b00010);
    chk("same_edge_valid", 32'(ov1), 32'd1);
    chk("same_edge_no_ovf", 32'(of1), 32'd0);
    tick();
    chk("same_edge_drained", 32'(ov1), 32'd0);

    // Multi-hot correction: fault is sticky and the XOR still applies.
    do_reset();
    push_exp(5'b11000, 5'b00000, 8'd1);
    beat(2'd0, 5'b11000);
    chk("fault_set", 32'(ft1), 32'd1);
    beat(2'd2, 5'b00000);
    tick();
    tick();
    tick();
    chk("fault_sticky", 32'(ft1), 32'd1);
    do_reset();
    chk("fault_cleared", 32'(ft1), 32'd0);

    // Reset in the middle of a window discards its partial contents.
    beat(2'd0, 5'b10000);
    beat(2'd1, 5'b00100);
    do_reset();
    push_exp(5'b00010, 5'b00001, 8'd2);
    beat(2'd0, 5'b00010);
    beat(2'd2, 5'b00001);
    tick();
    tick();

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pauli_frame_tracker.md
Name: pauli_frame_tracker

Overview:
- Downstream consumer of the syndrome-to-correction LUT stage.
- Each cycle it takes one 5-bit one-hot correction tagged with its axis (X/Y/Z) and folds it into a per-qubit Pauli frame (X bit and Z bit per data qubit).
- After ROUNDS complete X/Y/Z rounds it snapshots the frame into a single-entry output register with a valid/ready handshake, then clears the frame for the next window.

Parameters:
- N_QUBITS, 5, data qubits; width of correction and frame vectors.
- ROUNDS, 4, complete rounds per readout window; must be >= 1.
- CNT_W, 8, width of the round counter and the nonzero-correction counter.

Ports:
- CLK  in  1  clock, all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  correction/axis are valid this cycle.
- correction  in  N_QUBITS  one-hot (or zero) correction from the LUT stage.
- axis  in  2  0=X, 1=Y, 2=Z, 3=Z (3 is treated identically to 2).
- out_valid  out  1  snapshot register holds an unconsumed frame.
- out_ready  in  1  consumer accepts the snapshot when out_valid && out_ready.
- frame_x_out  out  N_QUBITS  snapshot X component.
- frame_z_out  out  N_QUBITS  snapshot Z component.
- corr_count_out  out  CNT_W  number of nonzero corrections in the window, saturating at all-ones.
- overflow  out  1  sticky: a snapshot was dropped because the output register was occupied.
- fault  out  1  sticky: an accepted correction had more than one bit set.

Behaviour:
- Reset: RST=1 at a posedge clears everything to 0: frame_x, frame_z, round counter, corr counter, out_valid, frame_x_out, frame_z_out, corr_count_out, overflow, fault. RST overrides all other inputs.
- Accumulate, when in_valid=1:
  - axis 0: frame_x ^= correction.
  - axis 1: frame_x ^= correction and frame_z ^= correction.
  - axis 2 or 3: frame_z ^= correction.
  - If correction != 0, corr counter increments, saturating at 2^CNT_W-1.
  - If popcount(correction) > 1, fault sets (sticky). The XOR is still applied.
- Rounds:
  - A round ends on an accepted beat with axis 2 or 3; the round counter then increments.
  - Beats with in_valid=0 change nothing.
  - Axis ordering is not checked.
- Window end: the beat that ends round ROUNDS (counter == ROUNDS-1 on that beat) triggers a snapshot.
  - Snapshot contents are the frame and corr counter values including that beat's own contribution.
  - Same posedge: frame, corr counter and round counter reset to 0.
- Output register FSM, states EMPTY and FULL:
  - EMPTY, snapshot due: load registers, go to FULL; out_valid=1 from the next cycle.
  - FULL, out_ready=1, no snapshot due: go to EMPTY.
  - FULL, out_ready=1, snapshot due on the same edge: load the new snapshot, stay FULL. No overflow.
  - FULL, out_ready=0, snapshot due: the new snapshot is discarded, the old one is kept, overflow sets. The frame is still cleared.
  - Output data registers are stable while out_valid=1 && out_ready=0.
- Latency: an input beat affects the internal frame at the next edge; a window-ending beat is visible on outputs 1 cycle later.
- Input is always accepted; there is no backpressure to the LUT stage.
- overflow and fault clear only on RST.

Decomposition:
- Shared package pauli_pkg:
  - Axis constants AXIS_X=2'd0, AXIS_Y=2'd1, AXIS_Z=2'd2.
  - N_QUBITS default.
  - Function is_z_axis(axis), returning axis[1].
- One natural sub-module, pauli_frame_outbuf: the single-entry EMPTY/FULL snapshot register with handshake and overflow flag, reusable by other window stages.
- Accumulation and counters stay in the top module.

Test Plan:
- Reset/idle: assert RST, then run 10 cycles with in_valid=0 -> all outputs 0, out_valid=0.
- Single window, ROUNDS=1:
  - Stimulus: beats (X,10000), (Y,00100), (Z,00001) with out_ready=1.
  - Required response: out_valid pulses 1 cycle after the Z beat; frame_x_out=10100, frame_z_out=00101, corr_count_out=3.
- Cancellation, ROUNDS=2:
  - Stimulus: X beat 01000 in both rounds, other beats zero.
  - Required response: frame_x_out=00000, corr_count_out=2.
  - Axis=3 is used for one Z beat and must behave as Z.
- Backpressure/overflow, ROUNDS=1, out_ready=0:
  - Stimulus: two full windows.
  - Required response: first snapshot held unchanged, overflow=1 after the second window end.
  - Then out_ready=1 -> out_valid drops next cycle.
  - A third window with out_ready=1 falling on the same cycle as the snapshot edge -> new data loaded, no extra overflow.
- Fault:
  - Stimulus: one X beat with correction=11000.
  - Required response: fault=1 sticky, frame_x XOR applied (11000 visible at window end); fault stays set until RST.
- Reset mid-window: assert RST after 2 beats of a window -> counters and frame cleared; the next full window reports only its own corrections.
